// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- iterative 32/32 divider for the execute stage (DIV / DIVU).
//
// One restoring shift-subtract step per clock on a 65-bit partial remainder.
// Signed operands are converted to magnitudes first. The quotient and
// remainder signs are fixed up when the result is presented.
//
// Ports
//   clk           in   1   rising-edge clock for all state
//   rst           in   1   synchronous, active-high reset
//   signed_div_i  in   1   1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
//   opdata1_i     in  32   dividend; sampled with start
//   opdata2_i     in  32   divisor; sampled with start
//   start_i       in   1   request; held high until ready_o is seen
//   annul_i       in   1   pipeline flush (only acted on with DIV_ANNUL_EN)
//   result_o      out 64   {remainder -> HI, quotient -> LO}
//   ready_o       out  1   result valid
//
// Optional feature
//   DIV_ANNUL_EN  when defined, annul_i forces IDLE from any state on the next
//                 edge, clears ready_o/result_o, and blocks start in IDLE.
//                 When undefined, annul_i is ignored.
//
// Timing, counted from the edge that samples start_i:
//   nonzero divisor: ready_o first high 33 edges later
//   zero divisor:    ready_o first high 2 edges later, result 64'h0
// ---------------------------------------------------------------------------
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t      state, next_state;
  logic [4:0]  cnt;
  logic [64:0] partial;
  logic [31:0] divisor_mag;
  logic        neg_quot;
  logic        neg_rem;

  logic        annul_act;
  logic        ready_d;
  logic [63:0] result_d;

`ifdef DIV_ANNUL_EN
  assign annul_act = annul_i;
`else
  logic annul_unused;
  assign annul_act    = 1'b0;
  assign annul_unused = annul_i;
`endif

  // Operand magnitudes; only meaningful on the cycle start is accepted.
  logic [31:0] dividend_mag_in, divisor_mag_in;
  assign dividend_mag_in = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign divisor_mag_in  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // Trial subtraction. The trial remainder lives in partial[64:32] and can
  // need 33 bits when the divisor is above 2^31, so the compare uses all 33.
  // When the subtraction succeeds the difference is below the divisor and
  // fits in 32 bits, so the low 32 bits of a plain subtract are exact.
  logic        trial_ok;
  logic [31:0] trial_diff;
  assign trial_ok   = partial[64:32] >= {1'b0, divisor_mag};
  assign trial_diff = partial[63:32] - divisor_mag;

  // Sign fix-up of the finished magnitudes: quotient low 32, remainder [64:33].
  // A zero divisor leaves partial cleared, so the fix-up yields zero as well.
  logic [31:0] quot_mag, rem_mag, quot_fin, rem_fin;
  assign quot_mag = partial[31:0];
  assign rem_mag  = partial[64:33];
  assign quot_fin = neg_quot ? (~quot_mag + 32'd1) : quot_mag;
  assign rem_fin  = neg_rem  ? (~rem_mag  + 32'd1) : rem_mag;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ready_o  <= 1'b0;
      result_o <= 64'h0;
    end else begin
      state    <= next_state;
      ready_o  <= ready_d;
      result_o <= result_d;
    end
  end

  // Next state and next output values. Outputs are only driven while END is
  // held; every other path leaves them at zero so result_o is 0 when ready_o is.
  always_comb begin
    next_state = state;
    ready_d    = 1'b0;
    result_d   = 64'h0;
    case (state)
      IDLE: begin
        if (start_i && !annul_act)
          next_state = (opdata2_i == 32'h0) ? BYZERO : ON;
      end
      BYZERO: begin
        next_state = start_i ? END : IDLE;
      end
      ON: begin
        if (!start_i)
          next_state = IDLE;
        else if (cnt == 5'd31)
          next_state = END;
      end
      END: begin
        // Staying in END while start is held keeps the result on the bus;
        // a fresh operation can only be accepted after passing through IDLE.
        if (start_i) begin
          ready_d  = 1'b1;
          result_d = {rem_fin, quot_fin};
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (annul_act) begin
      next_state = IDLE;
      ready_d    = 1'b0;
      result_d   = 64'h0;
    end
  end

  // Datapath: operand capture on acceptance, one division step per ON cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 5'd0;
      partial     <= 65'h0;
      divisor_mag <= 32'h0;
      neg_quot    <= 1'b0;
      neg_rem     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (next_state != IDLE) begin
            cnt         <= 5'd0;
            divisor_mag <= divisor_mag_in;
            neg_quot    <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem     <= signed_div_i && opdata1_i[31];
            if (opdata2_i == 32'h0)
              partial <= 65'h0;
            else
              partial <= {32'h0, dividend_mag_in, 1'b0};
          end
        end
        ON: begin
          cnt <= cnt + 5'd1;
          if (trial_ok)
            partial <= {trial_diff, partial[31:0], 1'b1};
          else
            partial <= {partial[63:0], 1'b0};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-004 SHALL have port opdata1_i  in  32  dividend; sampled with start.
REQ-005 SHALL have port opdata2_i  in  32  divisor; sampled with start.
REQ-006 SHALL have port start_i  in  1  request; held high by the execute stage until ready_o is seen.
REQ-007 SHALL have port annul_i  in  1  pipeline flush; abort the current operation.
REQ-008 SHALL have port result_o  out  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-009 SHALL have port ready_o  out  1  result valid (the execute stage's div_ready_i).

Function
REQ-010 SHALL implement FSM states IDLE, BYZERO, ON, END.
REQ-011 IDLE: start_i=1 and annul_i=0 SHALL latch opdata1_i, opdata2_i and signed_div_i, then go to BYZERO if divisor==0, else to ON with step counter cnt=0.
REQ-012 Latched operands SHALL be the only operands used; input changes after the sampling edge SHALL have no effect.
REQ-013 Signed mode SHALL convert each negative operand to its two's-complement magnitude before iterating.
REQ-014 ON SHALL perform one restoring shift-subtract step per cycle on a 65-bit partial remainder; after step 32 (cnt==31) it SHALL go to END.
REQ-015 Signed mode: quotient SHALL be negated when operand signs differ; remainder SHALL take the dividend's sign.
REQ-016 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000 (wrap) and remainder 0x00000000, with no exception.
REQ-017 BYZERO SHALL go to END with result 64'h0 on the next edge.
REQ-018 END: ready_o=1 and result_o SHALL hold stable; when start_i=0 the FSM SHALL go to IDLE, with ready_o=0 and result_o=0 the following cycle.
REQ-019 start_i=0 in ON or BYZERO SHALL abort to IDLE; no result is produced.
REQ-020 Latency: ready_o SHALL first be high 33 edges after the start-sampling edge for a nonzero divisor, and 2 edges after it for a zero divisor.
REQ-021 ready_o and result_o SHALL be registered outputs; result_o=0 whenever ready_o=0.
REQ-022 start_i held high through END SHALL not restart; a new operation requires one IDLE cycle.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, cnt=0, ready_o=0, result_o=64'h0, and clear the partial remainder, regardless of state (including mid-ON).
REQ-024 rst SHALL take priority over start_i and annul_i.

Configuration
REQ-025 Macro DIV_ANNUL_EN defined: annul_i=1 SHALL force IDLE next edge from any state, clear ready_o/result_o, and block start acceptance in IDLE.
REQ-026 Macro DIV_ANNUL_EN undefined: annul_i SHALL be ignored (port present, unused); only start_i deassertion aborts.

Verification
REQ-027 Unsigned 100/7, start held -> ready_o at edge 33, result_o=64'h00000002_0000000E; drop start -> ready_o=0 next cycle.
REQ-028 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=64'hFFFFFFFF_FFFFFFFD; unsigned same bits -> q=0x7FFFFFFC, r=1.
REQ-029 Divisor 0, any dividend -> ready_o at edge 2, result_o=64'h0.
REQ-030 Signed 0x80000000/0xFFFFFFFF -> result_o=64'h00000000_80000000.
REQ-031 Mid-ON (edge 10) rst=1, or annul_i=1 with DIV_ANNUL_EN -> IDLE, ready_o never asserts; new start 2 cycles later completes correctly.
REQ-032 Back-to-back operations: start dropped one cycle after ready, reasserted next cycle with 0xFFFFFFFF/0x10 unsigned -> result_o=64'h0000000F_0FFFFFFF.
